// File: rtl/camera_pkg.sv
// Shared definitions for the multi-row camera sequencer: state encoding,
// readout timing and the values the outputs take when nothing is happening.
package camera_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ERASE   = 2'd1,
        ST_EXPOSE  = 2'd2,
        ST_READOUT = 2'd3
    } cam_state_t;

    localparam int   ROW_CYC      = 3;
    localparam int   ADC_PHASE    = 1;
    localparam logic ERASE_IDLE   = 1'b0;
    localparam logic EXPOSE_IDLE  = 1'b0;
    localparam logic ADC_IDLE     = 1'b0;
    localparam logic NRE_IDLE_BIT = 1'b1;

endpackage

// File: rtl/camera_control_multi_exp_adjust.sv
// Saturating up/down exposure register; adjustments are accepted only while
// i_en is high so the setting cannot move in the middle of a frame.
module exp_adjust #(
    parameter int EXP_W     = 5,
    parameter int EXP_MIN   = 2,
    parameter int EXP_MAX   = 30,
    parameter int EXP_RESET = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [EXP_W-1:0] o_exp
);
    logic [EXP_W-1:0] r_exp;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_exp <= EXP_W'(EXP_RESET);
        end else if (i_en) begin
            if (i_inc && !i_dec && (r_exp != EXP_W'(EXP_MAX))) begin
                r_exp <= r_exp + EXP_W'(1);
            end else if (i_dec && !i_inc && (r_exp != EXP_W'(EXP_MIN))) begin
                r_exp <= r_exp - EXP_W'(1);
            end
        end
    end

    assign o_exp = r_exp;

endmodule

// File: rtl/camera_control_multi.sv
// Frame sequencer for a multi-row sensor: erase, timed exposure, then a
// three-cycle readout per row with an ADC strobe in the middle cycle.
//
// state      | meaning
// ST_IDLE    | waiting for init; exposure may be adjusted
// ST_ERASE   | one-cycle pixel erase strobe
// ST_EXPOSE  | exposure window, exp_time cycles long
// ST_READOUT | rows read 0..N_ROWS-1, ROW_CYC cycles each
module camera_control_multi
    import camera_pkg::*;
#(
    parameter int N_ROWS    = 2,
    parameter int EXP_W     = 5,
    parameter int EXP_MIN   = 2,
    parameter int EXP_MAX   = 30,
    parameter int EXP_RESET = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic              cont,
    input  logic              exp_inc,
    input  logic              exp_dec,
    output logic              erase,
    output logic              expose,
    output logic [N_ROWS-1:0] nre,
    output logic              adc,
    output logic              busy,
    output logic              frame_done,
    output logic [EXP_W-1:0]  exp_time
);
    localparam int ROW_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;

    if ((N_ROWS < 1) || (N_ROWS > 16) || (EXP_MIN < 1) || (EXP_MIN > EXP_MAX) ||
        (EXP_MAX >= (1 << EXP_W)) || (EXP_RESET < EXP_MIN) || (EXP_RESET > EXP_MAX)) begin : g_param_check
        $error("camera_control_multi: illegal parameter combination");
    end

    cam_state_t       r_state;
    cam_state_t       w_state_nxt;
    logic [EXP_W-1:0] r_exp_count;
    logic [ROW_W-1:0] r_row;
    logic [1:0]       r_phase;
    logic             w_last_row;
    logic             w_last_cycle;

    exp_adjust #(
        .EXP_W    (EXP_W),
        .EXP_MIN  (EXP_MIN),
        .EXP_MAX  (EXP_MAX),
        .EXP_RESET(EXP_RESET)
    ) u_exp_adjust (
        .clk   (clk),
        .reset (reset),
        .i_en  (r_state == ST_IDLE),
        .i_inc (exp_inc),
        .i_dec (exp_dec),
        .o_exp (exp_time)
    );

    assign w_last_row   = (r_row == ROW_W'(N_ROWS - 1));
    assign w_last_cycle = w_last_row && (r_phase == 2'(ROW_CYC - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:    if (init) w_state_nxt = ST_ERASE;
            ST_ERASE:   w_state_nxt = ST_EXPOSE;
            ST_EXPOSE:  if (r_exp_count == exp_time) w_state_nxt = ST_READOUT;
            ST_READOUT: if (w_last_cycle) w_state_nxt = cont ? ST_ERASE : ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // exp_count holds 1 on the first EXPOSE cycle and climbs to exp_time.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_exp_count <= '0;
            r_row       <= '0;
            r_phase     <= '0;
        end else begin
            if (r_state == ST_ERASE) begin
                r_exp_count <= EXP_W'(1);
            end else if ((r_state == ST_EXPOSE) && (w_state_nxt == ST_EXPOSE)) begin
                r_exp_count <= r_exp_count + EXP_W'(1);
            end else begin
                r_exp_count <= '0;
            end

            if (r_state == ST_READOUT) begin
                if (r_phase == 2'(ROW_CYC - 1)) begin
                    r_phase <= '0;
                    r_row   <= w_last_row ? '0 : r_row + ROW_W'(1);
                end else begin
                    r_phase <= r_phase + 2'd1;
                end
            end else begin
                r_row   <= '0;
                r_phase <= '0;
            end
        end
    end

    always_comb begin
        erase      = ERASE_IDLE;
        expose     = EXPOSE_IDLE;
        adc        = ADC_IDLE;
        nre        = {N_ROWS{NRE_IDLE_BIT}};
        busy       = (r_state != ST_IDLE);
        frame_done = 1'b0;
        unique case (r_state)
            ST_ERASE:   erase = 1'b1;
            ST_EXPOSE:  expose = 1'b1;
            ST_READOUT: begin
                nre[r_row] = 1'b0;
                adc        = (r_phase == 2'(ADC_PHASE));
                frame_done = w_last_cycle;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_camera_control_multi.sv
// Directed bench: default instance for exposure adjust, single/continuous
// frames and reset abort; a 4-row instance for row ordering and frame length.
module tb_camera_control_multi;

    logic       clk = 1'b0;
    logic       reset, init, cont, exp_inc, exp_dec;
    logic       erase, expose, adc, busy, frame_done;
    logic [1:0] nre;
    logic [4:0] exp_time;

    logic       init4, reset4;
    logic       erase4, expose4, adc4, busy4, frame_done4;
    logic [3:0] nre4;
    logic [5:0] exp_time4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    camera_control_multi dut (
        .clk(clk), .reset(reset), .init(init), .cont(cont),
        .exp_inc(exp_inc), .exp_dec(exp_dec),
        .erase(erase), .expose(expose), .nre(nre), .adc(adc),
        .busy(busy), .frame_done(frame_done), .exp_time(exp_time)
    );

    camera_control_multi #(.N_ROWS(4), .EXP_W(6), .EXP_MAX(40)) dut4 (
        .clk(clk), .reset(reset4), .init(init4), .cont(1'b0),
        .exp_inc(1'b0), .exp_dec(1'b0),
        .erase(erase4), .expose(expose4), .nre(nre4), .adc(adc4),
        .busy(busy4), .frame_done(frame_done4), .exp_time(exp_time4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // {erase, expose, nre[1:0], adc, busy, frame_done}
    function automatic logic [6:0] pk(input logic e, x, input logic [1:0] n, input logic a, b, f);
        return {e, x, n, a, b, f};
    endfunction

    initial begin
        reset = 1'b0; init = 1'b0; cont = 1'b0; exp_inc = 1'b0; exp_dec = 1'b0;
        reset4 = 1'b0; init4 = 1'b0;
        step(2);
        chk("reset_exp_time", 32'(exp_time), 32'd2);
        chk("reset_outputs", 32'(pk(erase, expose, nre, adc, busy, frame_done)),
            32'(pk(1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0)));
        reset = 1'b1; reset4 = 1'b1;
        step(1);

        exp_inc = 1'b1; step(40);
        chk("inc_saturate", 32'(exp_time), 32'd30);
        exp_inc = 1'b0; exp_dec = 1'b1; step(40);
        chk("dec_saturate", 32'(exp_time), 32'd2);
        exp_dec = 1'b0; exp_inc = 1'b1; step(3);
        chk("inc_to_5", 32'(exp_time), 32'd5);
        exp_dec = 1'b1; step(5);
        chk("inc_dec_both", 32'(exp_time), 32'd5);
        exp_inc = 1'b0; exp_dec = 1'b0; step(1);

        // single frame, exp_time=5; inc and init asserted while busy
        init = 1'b1; step(1); init = 1'b0;
        chk("f1_erase", 32'(pk(erase, expose, nre, adc, busy, frame_done)),
            32'(pk(1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0)));
        exp_inc = 1'b1; init = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("f1_expose", 32'(pk(erase, expose, nre, adc, busy, frame_done)),
                32'(pk(1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0)));
        end
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (i == 4) begin exp_inc = 1'b0; init = 1'b0; end
            chk("f1_readout", 32'(pk(erase, expose, nre, adc, busy, frame_done)),
                32'(pk(1'b0, 1'b0, (i < 3) ? 2'b10 : 2'b01, (i % 3) == 1, 1'b1, i == 5)));
        end
        step(1);
        chk("f1_idle", 32'(pk(erase, expose, nre, adc, busy, frame_done)),
            32'(pk(1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0)));
        chk("f1_exp_stable", 32'(exp_time), 32'd5);
        step(2);
        chk("f1_no_restart", 32'(busy), 32'd0);

        // continuous: 12-cycle period, cont dropped mid-EXPOSE of 2nd frame
        cont = 1'b1; init = 1'b1; step(1); init = 1'b0;
        chk("c_erase_t0", 32'(erase), 32'd1);
        for (int t = 1; t <= 24; t++) begin
            step(1);
            if (t == 14) cont = 1'b0;
            chk("c_erase", 32'(erase), 32'(t == 12));
            chk("c_done", 32'(frame_done), 32'(t == 11 || t == 23));
            chk("c_busy", 32'(busy), 32'(t != 24));
        end

        // reset during EXPOSE aborts the frame
        exp_inc = 1'b1; step(2); exp_inc = 1'b0;
        chk("r_exp7", 32'(exp_time), 32'd7);
        init = 1'b1; step(1); init = 1'b0; step(2);
        chk("r_in_expose", 32'(expose), 32'd1);
        reset = 1'b0; step(1);
        chk("r_abort", 32'(pk(erase, expose, nre, adc, busy, frame_done)),
            32'(pk(1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0)));
        chk("r_exp_time", 32'(exp_time), 32'd2);
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(1);
            chk("r_quiet", 32'({busy, frame_done}), 32'd0);
        end

        // 4-row instance, exp_time=2: 1 + 2 + 12 = 15 busy cycles
        chk("n4_reset", 32'({nre4, busy4, exp_time4}), 32'({4'hF, 1'b0, 6'd2}));
        init4 = 1'b1; step(1); init4 = 1'b0;
        chk("n4_erase", 32'(erase4), 32'd1);
        for (int i = 0; i < 2; i++) begin
            step(1);
            chk("n4_expose", 32'({expose4, nre4}), 32'({1'b1, 4'hF}));
        end
        for (int i = 0; i < 12; i++) begin
            step(1);
            chk("n4_nre", 32'(nre4), 32'(~(4'b0001 << (i / 3)) & 4'hF));
            chk("n4_adc_done", 32'({adc4, frame_done4, busy4}),
                32'({(i % 3) == 1, i == 11, 1'b1}));
        end
        step(1);
        chk("n4_idle", 32'({busy4, nre4}), 32'({1'b0, 4'hF}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
